// File: rtl/ieee_rom_loader.sv
// Byte-serial ROM image loader for the shared drive ROM port: owns the port and holds
// the drives in reset while a download targets this ROM, then releases both after a settle delay.
module ieee_rom_loader #(
  parameter int          ADDRWIDTH     = 14,
  parameter logic [7:0]  ROM_INDEX     = 8'd2,
  parameter int          RELEASE_DELAY = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dl_active,
  input  logic [7:0]           dl_index,
  input  logic [23:0]          dl_addr,
  input  logic [7:0]           dl_data,
  input  logic                 dl_wr,
  output logic                 dl_wait,
  input  logic [ADDRWIDTH-1:0] mux_addr,
  output logic [ADDRWIDTH-1:0] rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_wren,
  output logic                 drv_reset,
  output logic                 loaded,
  output logic [ADDRWIDTH:0]   byte_count,
  output logic [7:0]           checksum,
  output logic                 overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LOAD   = 3'd2,
    S_WRITE  = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  localparam logic [ADDRWIDTH:0] FULL  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] ONE   = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [7:0]         DELAY = 8'(RELEASE_DELAY);

  state_t               state;
  state_t               state_next;
  logic [7:0]           cnt;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 aborted;
  logic                 sel;
  logic                 in_range;
  logic                 arm_entry;

  assign sel       = dl_active && (dl_index == ROM_INDEX);
  assign in_range  = (dl_addr[23:ADDRWIDTH] == '0);
  assign arm_entry = (state_next == S_ARM) && (state != S_ARM);

  // State register plus settle counter; reset parks in SETTLE so drives start held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_SETTLE;
      cnt   <= DELAY;
    end else begin
      state <= state_next;
      if ((state_next == S_SETTLE) && (state != S_SETTLE)) cnt <= DELAY;
      else if ((state == S_SETTLE) && (cnt != 8'd0))       cnt <= cnt - 8'd1;
    end
  end

  // A strobe that lands together with sel falling still wins over the exit to SETTLE.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (sel) state_next = S_ARM;
      S_ARM:    state_next = S_LOAD;
      S_LOAD: begin
        if (dl_wr && in_range) state_next = S_WRITE;
        else if (!sel)         state_next = S_SETTLE;
      end
      S_WRITE:  state_next = S_LOAD;
      S_SETTLE: begin
        if (sel)               state_next = S_ARM;
        else if (cnt <= 8'd1)  state_next = S_IDLE;
      end
      default:  state_next = S_SETTLE;
    endcase
  end

  always_comb begin
    drv_reset = (state != S_IDLE);
    dl_wait   = ((state == S_ARM) || (state == S_WRITE)) && !reset;
    rom_wren  = (state == S_WRITE) && !reset;
    rom_addr  = (state == S_IDLE) ? mux_addr : wr_addr;
    rom_data  = wr_data;
  end

  // Load bookkeeping; every new arm starts a fresh image.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr    <= '0;
      wr_data    <= '0;
      byte_count <= '0;
      checksum   <= '0;
      overflow   <= 1'b0;
      loaded     <= 1'b0;
      aborted    <= 1'b1;
    end else if (arm_entry) begin
      byte_count <= '0;
      checksum   <= '0;
      overflow   <= 1'b0;
      loaded     <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if ((state == S_LOAD) && dl_wr && in_range) begin
        wr_addr <= dl_addr[ADDRWIDTH-1:0];
        wr_data <= dl_data;
      end
      if ((state == S_LOAD) && dl_wr && !in_range) overflow <= 1'b1;
      if (state == S_WRITE) begin
        if (byte_count != FULL) byte_count <= byte_count + ONE;
        checksum <= checksum + wr_data;
      end
      if ((state == S_SETTLE) && (state_next == S_IDLE) && !aborted && (byte_count == FULL))
        loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ieee_rom_loader.sv
// Bench for ieee_rom_loader: table-driven short images, directed corner sequences,
// a full image load and randomized downloads checked against a transaction-level model.
module tb_ieee_rom_loader;

  localparam int AW   = 14;
  localparam int FULL = 16384;
  localparam int DLY  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dl_active = 1'b0;
  logic [7:0]    dl_index = 8'd0;
  logic [23:0]   dl_addr = 24'd0;
  logic [7:0]    dl_data = 8'd0;
  logic          dl_wr = 1'b0;
  logic          dl_wait;
  logic [AW-1:0] mux_addr = '0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_wren;
  logic          drv_reset;
  logic          loaded;
  logic [AW:0]   byte_count;
  logic [7:0]    checksum;
  logic          overflow;

  ieee_rom_loader #(.ADDRWIDTH(AW), .ROM_INDEX(8'd2), .RELEASE_DELAY(DLY)) dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_index(dl_index),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr), .dl_wait(dl_wait),
    .mux_addr(mux_addr), .rom_addr(rom_addr), .rom_data(rom_data), .rom_wren(rom_wren),
    .drv_reset(drv_reset), .loaded(loaded), .byte_count(byte_count),
    .checksum(checksum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [AW+7:0] exp_q[$];

  // Transaction-level model: which strobes are taken, and when SETTLE begins.
  bit         m_sel = 1'b0;
  int         m_ready = 0;
  int         m_count = 0;
  logic [7:0] m_sum = 8'd0;
  bit         m_ovf = 1'b0;
  int         m_entry = 0;
  int         m_drop = 0;

  typedef struct {
    logic [AW-1:0] mux;
    logic [AW-1:0] exp_addr;
  } mux_vec_t;

  typedef struct {
    int         n;
    int         start;
    int         exp_count;
    logic [7:0] exp_sum;
    bit         exp_ovf;
  } img_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [AW+7:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rom_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", rom_addr, rom_data);
      end else begin
        e = exp_q.pop_front();
        check("write", {rom_addr, rom_data}, e);
      end
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    dl_active = 1'b1;
    dl_index  = idx;
    if (idx == 8'd2) begin
      m_sel   = 1'b1;
      m_ready = cyc + 3;
      m_count = 0;
      m_sum   = 8'd0;
      m_ovf   = 1'b0;
    end else begin
      m_sel = 1'b0;
    end
    tick();
  endtask

  task automatic send_byte(input logic [23:0] a, input logic [7:0] d, input bit drop);
    int e;
    e = cyc + 1;
    dl_wr = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (drop) dl_active = 1'b0;
    if (m_sel && (e >= m_ready)) begin
      if (a < FULL) begin
        exp_q.push_back({a[AW-1:0], d});
        if (m_count < FULL) m_count++;
        m_sum = m_sum + d;
        m_ready = e + 2;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (drop) begin
      m_drop  = e;
      m_entry = (m_ready > e) ? m_ready : e;
    end
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic end_dl();
    int e;
    e = cyc + 1;
    dl_active = 1'b0;
    m_drop  = e;
    m_entry = (m_ready > e) ? m_ready : e;
    tick();
  endtask

  task automatic measure_release(output int n);
    n = 0;
    while ((drv_reset === 1'b1) && (n < 400)) begin
      n++;
      tick();
    end
  endtask

  task automatic check_results();
    check("byte_count", byte_count, m_count);
    check("checksum", checksum, m_sum);
    check("overflow", overflow, m_ovf);
    check("pending_writes", exp_q.size(), 0);
  endtask

  mux_vec_t mux_vec[4];
  img_vec_t img_vec[4];

  initial begin
    int n;
    logic [23:0] a;
    mux_vec[0] = '{14'h1234, 14'h1234};
    mux_vec[1] = '{14'h0000, 14'h0000};
    mux_vec[2] = '{14'h3FFF, 14'h3FFF};
    mux_vec[3] = '{14'h2AAA, 14'h2AAA};
    img_vec[0] = '{100, 0, 100, 8'h56, 1'b0};
    img_vec[1] = '{1, 5, 1, 8'h05, 1'b0};
    img_vec[2] = '{3, 16382, 2, 8'hFD, 1'b1};
    img_vec[3] = '{10, 250, 10, 8'hF1, 1'b0};

    // Reset values and release after reset.
    tick();
    tick();
    check("rst_dl_wait", dl_wait, 0);
    check("rst_rom_wren", rom_wren, 0);
    check("rst_rom_data", rom_data, 0);
    check("rst_drv_reset", drv_reset, 1);
    check("rst_loaded", loaded, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_checksum", checksum, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    measure_release(n);
    check("release_after_reset", n, DLY);

    for (int i = 0; i < 4; i++) begin
      mux_addr = mux_vec[i].mux;
      #1;
      check("idle_rom_addr", rom_addr, mux_vec[i].exp_addr);
    end
    check("idle_drv_reset", drv_reset, 0);

    // Short images from the table.
    for (int i = 0; i < 4; i++) begin
      start_dl(8'd2);
      tick();
      for (int j = 0; j < img_vec[i].n; j++) begin
        a = 24'(img_vec[i].start + j);
        send_byte(a, a[7:0], 1'b0);
        tick();
      end
      end_dl();
      measure_release(n);
      check("img_release", n, m_entry + DLY - m_drop);
      check("img_byte_count", byte_count, img_vec[i].exp_count);
      check("img_checksum", checksum, img_vec[i].exp_sum);
      check("img_overflow", overflow, img_vec[i].exp_ovf);
      check("img_loaded", loaded, 0);
      check_results();
    end

    // Back-to-back strobe: the second one lands while dl_wait is high.
    start_dl(8'd2);
    tick();
    send_byte(24'h10, 8'hAA, 1'b0);
    check("b2b_wait_high", dl_wait, 1);
    send_byte(24'h11, 8'hBB, 1'b0);
    check("b2b_wait_low", dl_wait, 0);
    tick();
    end_dl();
    measure_release(n);
    check("b2b_release", n, DLY);
    check("b2b_count", byte_count, 1);
    check("b2b_checksum", checksum, 8'hAA);
    check_results();

    // Strobe together with sel falling, then re-arm during SETTLE.
    start_dl(8'd2);
    tick();
    send_byte(24'h20, 8'h33, 1'b1);
    check("drop_count_pending", exp_q.size(), 0);
    repeat (4) tick();
    check("drop_in_settle", drv_reset, 1);
    check("drop_count", byte_count, 1);
    check("drop_checksum", checksum, 8'h33);
    start_dl(8'd2);
    check("rearm_wait", dl_wait, 1);
    check("rearm_drv_reset", drv_reset, 1);
    tick();
    send_byte(24'h21, 8'h44, 1'b1);
    measure_release(n);
    check("drop_release", n, DLY + 2);
    check("rearm_count", byte_count, 1);
    check("rearm_checksum", checksum, 8'h44);
    check_results();

    // Full image with one out-of-range byte in the middle.
    start_dl(8'd2);
    tick();
    for (int j = 0; j < FULL; j++) begin
      if (j == FULL / 2) begin
        send_byte(24'h4000, 8'h77, 1'b0);
        check("ovf_count_held", byte_count, FULL / 2);
        check("ovf_flag", overflow, 1);
        tick();
      end
      a = 24'(j);
      send_byte(a, a[7:0], 1'b0);
      tick();
    end
    end_dl();
    measure_release(n);
    check("full_release", n, DLY);
    check("full_count", byte_count, FULL);
    check("full_checksum", checksum, 8'h00);
    check("full_overflow", overflow, 1);
    check("full_loaded", loaded, 1);
    check_results();

    // Foreign index: no writes, drives untouched, results kept.
    start_dl(8'd1);
    for (int j = 0; j < 5; j++) begin
      send_byte(24'(j), 8'h5A, 1'b0);
      check("foreign_drv_reset", drv_reset, 0);
      tick();
    end
    end_dl();
    check("foreign_after", drv_reset, 0);
    check("foreign_loaded", loaded, 1);
    check_results();

    // Reset in the WRITE cycle.
    start_dl(8'd2);
    tick();
    send_byte(24'h55, 8'h66, 1'b0);
    reset = 1'b1;
    #1;
    check("reset_wren", rom_wren, 0);
    dl_active = 1'b0;
    m_sel = 1'b0;
    m_count = 0;
    m_sum = 8'd0;
    m_ovf = 1'b0;
    tick();
    reset = 1'b0;
    measure_release(n);
    check("reset_release", n, DLY);
    check("reset_loaded", loaded, 0);
    check_results();

    // Randomized downloads.
    for (int it = 0; it < 25; it++) begin
      int nb;
      bit dropped;
      start_dl(8'd2);
      nb = $urandom_range(1, 30);
      dropped = 1'b0;
      for (int j = 0; j < nb; j++) begin
        int gap;
        gap = $urandom_range(1, 3);
        repeat (gap - 1) tick();
        if ($urandom_range(0, 7) == 0) a = 24'($urandom_range(24'hFFFFFF, 24'h4000));
        else                           a = 24'($urandom_range(16383, 0));
        dropped = (j == nb - 1) && ($urandom_range(0, 2) == 0);
        send_byte(a, 8'($urandom_range(255, 0)), dropped);
      end
      if (!dropped) begin
        repeat ($urandom_range(0, 2)) tick();
        end_dl();
      end
      if ((it < 24) && ($urandom_range(0, 3) == 0)) begin
        int r;
        r = $urandom_range(0, 10);
        while (cyc < m_entry + r) tick();
        check_results();
      end else begin
        measure_release(n);
        check("rand_release", n, m_entry + DLY - m_drop);
        check("rand_loaded", loaded, 0);
        check_results();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
